// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and decode helpers for the alu_seq execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADDU  = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUBU  = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_SLTU  = 4'h6;
  localparam logic [3:0] OP_SLT   = 4'h7;
  localparam logic [3:0] OP_MULTU = 4'h8;
  localparam logic [3:0] OP_MULT  = 4'h9;
  localparam logic [3:0] OP_DIVU  = 4'hA;
  localparam logic [3:0] OP_DIV   = 4'hB;

  localparam logic KIND_MUL = 1'b0;
  localparam logic KIND_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_long(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op[3:1] == 3'b101);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative magnitude shift-add multiplier / restoring divider, one bit per cycle,
// with sign correction applied to the held accumulator once iteration ends.
module muldiv_core
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         kind,
  input  logic         sgn,
  input  logic         abort,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [2*N-1:0] acc_r, acc_nx_s, prod_s;
  logic [N-1:0]   bmag_r, a_mag_s, b_mag_s;
  logic [CW-1:0]  cnt_r;
  logic           run_r, div_r, neg_lo_r, neg_hi_r;
  logic [N:0]     upper_s, diff_s, madd_s;

  assign done = run_r && (cnt_r == LAST);

  // Operand magnitudes and the next accumulator value for one iteration.
  always_comb begin
    a_mag_s  = (sgn && a[N-1]) ? ({N{1'b0}} - a) : a;
    b_mag_s  = (sgn && b[N-1]) ? ({N{1'b0}} - b) : b;
    upper_s  = acc_r[2*N-1:N-1];
    diff_s   = upper_s - {1'b0, bmag_r};
    madd_s   = {1'b0, acc_r[2*N-1:N]} + {1'b0, bmag_r};
    acc_nx_s = acc_r;
    if (div_r == KIND_DIV) begin
      // Bit N of the trial difference is the borrow: set means restore.
      if (!diff_s[N]) begin
        acc_nx_s = {diff_s[N-1:0], acc_r[N-2:0], 1'b1};
      end else begin
        acc_nx_s = {acc_r[2*N-2:0], 1'b0};
      end
    end else begin
      if (acc_r[0]) begin
        acc_nx_s = {madd_s, acc_r[N-1:1]};
      end else begin
        acc_nx_s = {1'b0, acc_r[2*N-1:1]};
      end
    end
  end

  // Signed results: negate the full product, or quotient and remainder separately.
  always_comb begin
    prod_s = neg_lo_r ? ({(2*N){1'b0}} - acc_r) : acc_r;
    if (div_r == KIND_DIV) begin
      lo = neg_lo_r ? ({N{1'b0}} - acc_r[N-1:0]) : acc_r[N-1:0];
      hi = neg_hi_r ? ({N{1'b0}} - acc_r[2*N-1:N]) : acc_r[2*N-1:N];
    end else begin
      lo = prod_s[N-1:0];
      hi = prod_s[2*N-1:N];
    end
  end

  // Operand load, per-cycle iteration and cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r    <= {(2*N){1'b0}};
      bmag_r   <= {N{1'b0}};
      cnt_r    <= {CW{1'b0}};
      run_r    <= 1'b0;
      div_r    <= 1'b0;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
    end else if (start) begin
      acc_r    <= {{N{1'b0}}, a_mag_s};
      bmag_r   <= b_mag_s;
      cnt_r    <= {CW{1'b0}};
      run_r    <= 1'b1;
      div_r    <= kind;
      neg_lo_r <= sgn & (a[N-1] ^ b[N-1]);
      neg_hi_r <= sgn & a[N-1];
    end else if (abort) begin
      run_r <= 1'b0;
      cnt_r <= {CW{1'b0}};
    end else if (run_r) begin
      acc_r <= acc_nx_s;
      if (done) begin
        run_r <= 1'b0;
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU: single-cycle arithmetic/logic/compare plus an
// iterative mul/div core behind a start/busy/done handshake with registered results.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         input_start,
  input  logic         input_abort,
  input  logic [3:0]   input_aluctr,
  input  logic [N-1:0] input_a,
  input  logic [N-1:0] input_b,
  output logic [N-1:0] out_result,
  output logic [N-1:0] out_result_hi,
  output logic         out_zero,
  output logic         out_overflow,
  output logic         out_busy,
  output logic         out_done
);

  state_t       state_r, state_nx_s;
  logic [N-1:0] result_r, hi_r, res_s, hi_s, sum_s, diff_s, core_hi_s, core_lo_s;
  logic         zero_r, ovf_r, done_r, zero_s, ovf_s, load_s;
  logic         accept_s, long_go_s, core_abort_s, core_done_s;
  logic         add_ovf_s, sub_ovf_s, slt_s, sltu_s;

  muldiv_core #(.N(N)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (long_go_s),
    .kind  (is_div(input_aluctr)),
    .sgn   (input_aluctr[0]),
    .abort (core_abort_s),
    .a     (input_a),
    .b     (input_b),
    .done  (core_done_s),
    .hi    (core_hi_s),
    .lo    (core_lo_s)
  );

  // Single-cycle datapath and the decision to launch an iterative op.
  always_comb begin
    sum_s        = input_a + input_b;
    diff_s       = input_a - input_b;
    add_ovf_s    = (input_a[N-1] == input_b[N-1]) && (sum_s[N-1] != input_a[N-1]);
    sub_ovf_s    = (input_a[N-1] != input_b[N-1]) && (diff_s[N-1] != input_a[N-1]);
    slt_s        = diff_s[N-1] ^ sub_ovf_s;
    sltu_s       = (input_a < input_b);
    accept_s     = (state_r == IDLE) && input_start;
    // A zero divisor completes immediately instead of iterating.
    long_go_s    = accept_s && is_long(input_aluctr)
                   && !(is_div(input_aluctr) && (input_b == {N{1'b0}}));
    core_abort_s = input_abort && (state_r != IDLE);
  end

  // Next state and the values loaded into the output registers on completion.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    res_s      = {N{1'b0}};
    hi_s       = {N{1'b0}};
    zero_s     = 1'b0;
    ovf_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (long_go_s) begin
          state_nx_s = RUN;
        end else if (accept_s) begin
          load_s = 1'b1;
          case (input_aluctr)
            OP_ADDU: begin res_s = sum_s;  zero_s = ~|sum_s; end
            OP_ADD:  begin res_s = sum_s;  zero_s = ~|sum_s;  ovf_s = add_ovf_s; end
            OP_SUBU: begin res_s = diff_s; zero_s = ~|diff_s; end
            OP_SUB:  begin res_s = diff_s; zero_s = ~|diff_s; ovf_s = sub_ovf_s; end
            OP_OR:   begin res_s = input_a | input_b; zero_s = ~|(input_a | input_b); end
            OP_AND:  begin res_s = input_a & input_b; zero_s = ~|(input_a & input_b); end
            OP_SLTU: res_s = {{(N-1){1'b0}}, sltu_s};
            OP_SLT:  res_s = {{(N-1){1'b0}}, slt_s};
            OP_DIVU, OP_DIV: begin res_s = {N{1'b1}}; hi_s = input_a; end
            default: res_s = {N{1'b0}};
          endcase
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (input_abort) begin
          state_nx_s = IDLE;
        end else if (core_done_s) begin
          state_nx_s = FIX;
        end else begin
          state_nx_s = RUN;
        end
      end
      FIX: begin
        state_nx_s = IDLE;
        if (!input_abort) begin
          load_s = 1'b1;
          res_s  = core_lo_s;
          hi_s   = core_hi_s;
          zero_s = ~|core_lo_s;
        end else begin
          load_s = 1'b0;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM state and result registers; results change only when an op completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      result_r <= {N{1'b0}};
      hi_r     <= {N{1'b0}};
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      done_r  <= load_s;
      if (load_s) begin
        result_r <= res_s;
        hi_r     <= hi_s;
        zero_r   <= zero_s;
        ovf_r    <= ovf_s;
      end
    end
  end

  assign out_result    = result_r;
  assign out_result_hi = hi_r;
  assign out_zero      = zero_r;
  assign out_overflow  = ovf_r;
  assign out_busy      = (state_r != IDLE);
  assign out_done      = done_r;

endmodule
